// File: rtl/fp_wb_pkg.sv
// Shared types and constants for the FP writeback arbiter.
// The entry record holds one pending FP register write.
package fp_wb_pkg;

  localparam int FP_REG_NUM = 32;
  localparam int FP_AW      = $clog2(FP_REG_NUM);

  localparam logic SRC_FPU = 1'b0;
  localparam logic SRC_LD  = 1'b1;

  typedef struct packed {
    logic [FP_AW-1:0] addr;
    logic [31:0]      data;
    logic [31:0]      inst_num;
  } wb_entry_t;

  function automatic wb_entry_t make_entry(input logic [FP_AW-1:0] addr,
                                           input logic [31:0]      data,
                                           input logic [31:0]      inst_num);
    wb_entry_t e;
    e.addr     = addr;
    e.data     = data;
    e.inst_num = inst_num;
    return e;
  endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// In-order circular buffer of pending FPU results.
// Pointers wrap explicitly, so DEPTH need not be a power of two.
module wb_result_fifo
  import fp_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  wb_entry_t                  din_i,
  output wb_entry_t                  dout_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  wb_entry_t     mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // A push into a full buffer only succeeds when the head leaves the same cycle.
  assign push_ok = push_i && (!full_o || pop_i);
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wrap_inc(wr_ptr_q);
    if (pop_ok)  rd_ptr_d = wrap_inc(rd_ptr_q);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/fp_writeback_arbiter.sv
// Arbitrates the single FP regfile write port between the non-stallable FPU
// result stream and the valid/ready load stream, with load starvation relief.
module fp_writeback_arbiter
  import fp_wb_pkg::*;
#(
  parameter int REG_NUM      = FP_REG_NUM,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 3,
  localparam int AW          = $clog2(REG_NUM),
  localparam int CW          = $clog2(FIFO_DEPTH+1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          fpu_valid,
  input  logic [AW-1:0] fpu_addr,
  input  logic [31:0]   fpu_data,
  input  logic [31:0]   fpu_inst_num,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data,
  input  logic [31:0]   ld_inst_num,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [31:0]   rf_wdata,
  output logic          sb_clear_en,
  output logic [AW-1:0] sb_clear_addr,
  output logic [31:0]   wb_inst_num,
  output logic          wb_src,
  output logic [CW-1:0] fifo_count,
  output logic          overflow_err
);

  // Handshake: a load transfers in any cycle where ld_valid && ld_ready;
  // ld_ready is combinational and never depends on ld_ready itself.

  localparam int SW = $clog2(STARVE_LIMIT+1);

  wb_entry_t     head_entry, fpu_entry, ld_entry, win_entry;
  logic          fifo_full, fifo_empty;
  logic          ld_grant, fpu_win, starved;
  logic          push_req, push, pop, drop;

  logic          rf_we_q, rf_we_d;
  wb_entry_t     wr_q, wr_d;
  logic          src_q, src_d;
  logic          ovf_q, ovf_d;
  logic [SW-1:0] starve_q, starve_d;

  assign fpu_entry = make_entry(fpu_addr, fpu_data, fpu_inst_num);
  assign ld_entry  = make_entry(ld_addr, ld_data, ld_inst_num);
  assign starved   = (starve_q == SW'(STARVE_LIMIT));

  always_comb begin
    ld_grant = ld_valid &&
               ((fifo_empty && !fpu_valid) ||
                (starved && (!fifo_full || !fpu_valid)));
    fpu_win  = !ld_grant && (!fifo_empty || fpu_valid);
    pop      = fpu_win && !fifo_empty;
    // A live FPU result must queue whenever it is not the one being written.
    push_req = fpu_valid && (!fifo_empty || ld_grant);
    push     = push_req && (!fifo_full || pop);
    drop     = push_req && fifo_full && !pop;
  end

  always_comb begin
    win_entry = fpu_entry;
    if (ld_grant)         win_entry = ld_entry;
    else if (!fifo_empty) win_entry = head_entry;
  end

  always_comb begin
    rf_we_d  = ld_grant || fpu_win;
    wr_d     = wr_q;
    src_d    = src_q;
    ovf_d    = ovf_q || drop;
    starve_d = '0;
    if (rf_we_d) begin
      wr_d  = win_entry;
      src_d = ld_grant ? SRC_LD : SRC_FPU;
    end
    if (ld_valid && !ld_grant)
      starve_d = starved ? starve_q : starve_q + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rf_we_q  <= 1'b0;
      wr_q     <= '0;
      src_q    <= SRC_FPU;
      ovf_q    <= 1'b0;
      starve_q <= '0;
    end else begin
      rf_we_q  <= rf_we_d;
      wr_q     <= wr_d;
      src_q    <= src_d;
      ovf_q    <= ovf_d;
      starve_q <= starve_d;
    end
  end

  wb_result_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (fpu_entry),
    .dout_o  (head_entry),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign ld_ready      = ld_grant;
  assign rf_we         = rf_we_q;
  assign rf_waddr      = wr_q.addr;
  assign rf_wdata      = wr_q.data;
  assign wb_inst_num   = wr_q.inst_num;
  assign wb_src        = src_q;
  assign sb_clear_en   = rf_we_q;
  assign sb_clear_addr = wr_q.addr;
  assign overflow_err  = ovf_q;

endmodule
